// File: rtl/icache_refill_if.sv
// Signal bundle linking the instruction-cache refill engine to the cache and to instruction memory.
// The master modport is the refill engine; the slave modport is the cache/memory side.
interface icache_refill_if;
    logic         miss_req;
    logic [31:0]  miss_addr;
    logic         stall;
    logic         mem_req;
    logic [31:0]  mem_addr;
    logic         mem_ack;
    logic [31:0]  mem_rdata;
    logic [127:0] dataline;
    logic [31:0]  line_addr;
    logic         line_valid;
    logic         crit_valid;
    logic [31:0]  crit_word;
    logic         refill_err;

    modport master (
        input  miss_req, miss_addr, mem_ack, mem_rdata,
        output stall, mem_req, mem_addr, dataline, line_addr, line_valid,
               crit_valid, crit_word, refill_err
    );

    modport slave (
        output miss_req, miss_addr, mem_ack, mem_rdata,
        input  stall, mem_req, mem_addr, dataline, line_addr, line_valid,
               crit_valid, crit_word, refill_err
    );
endinterface

// File: rtl/icache_refill.sv
// Line-fill engine: fetches the four words of a missed 16-byte line and hands the line to the cache.
// Optional macro REFILL_CRIT_FIRST_EN: fetch starts at the missed word and the critical word is pulsed early.
module icache_refill #(
    parameter int unsigned MAX_WAIT = 255
) (
    input  logic           clk,
    input  logic           reset,
    icache_refill_if.master bus
);
    localparam int unsigned WAIT_W = $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FETCH   = 3'd1,
        DELIVER = 3'd2,
        DRAIN   = 3'd3,
        ERROR   = 3'd4
    } state_t;

    state_t              r_state;
    logic [27:0]         r_base;
    logic [1:0]          r_cnt;
    logic [1:0]          r_fetched;
    logic [WAIT_W-1:0]   r_wait;
    logic [127:0]        r_buf;
    logic                r_stall;
    logic                r_mem_req;
    logic [31:0]         r_mem_addr;
    logic [127:0]        r_dataline;
    logic [31:0]         r_line_addr;
    logic                r_line_valid;
    logic                r_refill_err;
`ifdef REFILL_CRIT_FIRST_EN
    logic                r_crit_valid;
    logic [31:0]         r_crit_word;
`endif

    logic [1:0]          w_start;
    logic [1:0]          w_next_cnt;
    logic                w_accept;
    logic [127:0]        w_fill_buf;
    logic                w_unused;

`ifdef REFILL_CRIT_FIRST_EN
    assign w_start = bus.miss_addr[3:2];
`else
    assign w_start = 2'b00;
`endif
    assign w_next_cnt = r_cnt + 2'd1;
    assign w_accept   = bus.mem_ack & r_mem_req;
    assign w_unused   = &{1'b0, bus.miss_addr[3:0]};

    // Merge the returning word into its slot of the private assembly buffer.
    always_comb begin
        w_fill_buf = r_buf;
        case (r_cnt)
            2'd0:    w_fill_buf[31:0]   = bus.mem_rdata;
            2'd1:    w_fill_buf[63:32]  = bus.mem_rdata;
            2'd2:    w_fill_buf[95:64]  = bus.mem_rdata;
            2'd3:    w_fill_buf[127:96] = bus.mem_rdata;
            default: w_fill_buf = r_buf;
        endcase
    end

    // Refill sequencer; every output is a register so the cache sees glitch-free controls.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_base       <= 28'd0;
            r_cnt        <= 2'd0;
            r_fetched    <= 2'd0;
            r_wait       <= '0;
            r_buf        <= 128'd0;
            r_stall      <= 1'b0;
            r_mem_req    <= 1'b0;
            r_mem_addr   <= 32'd0;
            r_dataline   <= 128'd0;
            r_line_addr  <= 32'd0;
            r_line_valid <= 1'b0;
            r_refill_err <= 1'b0;
`ifdef REFILL_CRIT_FIRST_EN
            r_crit_valid <= 1'b0;
            r_crit_word  <= 32'd0;
`endif
        end else begin
            r_line_valid <= 1'b0;
`ifdef REFILL_CRIT_FIRST_EN
            r_crit_valid <= 1'b0;
`endif
            case (r_state)
                IDLE: begin
                    if (bus.miss_req) begin
                        r_base     <= bus.miss_addr[31:4];
                        r_cnt      <= w_start;
                        r_fetched  <= 2'd0;
                        r_wait     <= '0;
                        r_stall    <= 1'b1;
                        r_mem_req  <= 1'b1;
                        r_mem_addr <= {bus.miss_addr[31:4], w_start, 2'b00};
                        r_state    <= FETCH;
                    end else begin
                        r_stall    <= 1'b0;
                    end
                end
                FETCH: begin
                    if (w_accept) begin
                        r_buf     <= w_fill_buf;
                        r_cnt     <= w_next_cnt;
                        r_fetched <= r_fetched + 2'd1;
                        r_wait    <= '0;
`ifdef REFILL_CRIT_FIRST_EN
                        if (r_fetched == 2'd0) begin
                            r_crit_valid <= 1'b1;
                            r_crit_word  <= bus.mem_rdata;
                        end
`endif
                        // Only a complete line is ever published to the cache.
                        if (r_fetched == 2'd3) begin
                            r_mem_req    <= 1'b0;
                            r_dataline   <= w_fill_buf;
                            r_line_addr  <= {r_base, 4'b0000};
                            r_line_valid <= 1'b1;
                            r_state      <= DELIVER;
                        end else begin
                            r_mem_addr   <= {r_base, w_next_cnt, 2'b00};
                        end
                    end else if (r_wait == WAIT_LAST) begin
                        r_mem_req    <= 1'b0;
                        r_refill_err <= 1'b1;
                        r_state      <= ERROR;
                    end else begin
                        r_wait       <= r_wait + WAIT_W'(1);
                    end
                end
                DELIVER: begin
                    r_state <= DRAIN;
                end
                DRAIN: begin
                    r_stall <= 1'b0;
                    r_state <= IDLE;
                end
                ERROR: begin
                    r_state <= ERROR;
                end
                default: begin
                    r_mem_req <= 1'b0;
                    r_stall   <= 1'b0;
                    r_state   <= IDLE;
                end
            endcase
        end
    end

    assign bus.stall      = r_stall;
    assign bus.mem_req    = r_mem_req;
    assign bus.mem_addr   = r_mem_addr;
    assign bus.dataline   = r_dataline;
    assign bus.line_addr  = r_line_addr;
    assign bus.line_valid = r_line_valid;
    assign bus.refill_err = r_refill_err;
`ifdef REFILL_CRIT_FIRST_EN
    assign bus.crit_valid = r_crit_valid;
    assign bus.crit_word  = r_crit_word;
`else
    assign bus.crit_valid = 1'b0;
    assign bus.crit_word  = 32'd0;
`endif
endmodule

// File: tb/tb_icache_refill.sv
// Randomized bench for icache_refill: a transaction-level model predicts every output each cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_icache_refill;
    localparam int TB_MAX_WAIT = 8;
`ifdef REFILL_CRIT_FIRST_EN
    localparam bit CRIT = 1'b1;
`else
    localparam bit CRIT = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    icache_refill_if bus ();
    icache_refill #(.MAX_WAIT(TB_MAX_WAIT)) dut (.clk(clk), .reset(reset), .bus(bus));

    int checks = 0;
    int errors = 0;

    // stimulus knobs shared with the memory responder
    int lat_mode   = 1;     // <0 : random latency per word
    bit fixed_data = 1'b1;
    bit spur_en    = 1'b0;

    // observations kept by the model/responder processes
    logic [31:0]  acc_q[$];
    int           lv_count   = 0;
    int           req_cycles = 0;
    logic [127:0] cap_line   = 128'd0;
    logic [31:0]  cap_laddr  = 32'd0;
    logic [31:0]  cap_crit   = 32'd0;

    // model state
    int           m_phase = 0;   // 0 idle, 1 fetching, 2 line offered, 3 settle cycle, 4 timed out
    logic [31:0]  m_base  = 32'd0;
    int           m_start = 0;
    int           m_n     = 0;
    int           m_wait  = 0;
    bit           m_fresh = 1'b1;
    logic [31:0]  m_words [4];
    logic [127:0] e_dataline  = 128'd0;
    logic [31:0]  e_line_addr = 32'd0;
    logic [31:0]  e_crit_word = 32'd0;
    bit           e_crit_valid = 1'b0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Model: advance on each sampled edge, then compare DUT outputs once they have settled.
    initial begin : model
        bit          s_reset, s_miss, s_ack;
        logic [31:0] s_maddr, s_rdata;
        forever begin
            @(posedge clk);
            s_reset = reset; s_miss = bus.miss_req; s_maddr = bus.miss_addr;
            s_ack = bus.mem_ack; s_rdata = bus.mem_rdata;
            e_crit_valid = 1'b0;
            if (s_reset) begin
                m_phase = 0; m_n = 0; m_wait = 0; m_fresh = 1'b1;
                e_dataline = 128'd0; e_line_addr = 32'd0; e_crit_word = 32'd0;
            end else begin
                case (m_phase)
                    0: if (s_miss) begin
                        m_base  = {s_maddr[31:4], 4'h0};
                        m_start = CRIT ? int'(s_maddr[3:2]) : 0;
                        m_n = 0; m_wait = 0; m_fresh = 1'b0; m_phase = 1;
                    end
                    1: if (s_ack) begin
                        m_words[(m_start + m_n) % 4] = s_rdata;
                        if (CRIT && m_n == 0) begin
                            e_crit_valid = 1'b1;
                            e_crit_word  = s_rdata;
                        end
                        m_n++; m_wait = 0;
                        if (m_n == 4) begin
                            m_phase     = 2;
                            e_dataline  = {m_words[3], m_words[2], m_words[1], m_words[0]};
                            e_line_addr = m_base;
                        end
                    end else begin
                        m_wait++;
                        if (m_wait >= TB_MAX_WAIT) m_phase = 4;
                    end
                    2: m_phase = 3;
                    3: m_phase = 0;
                    default: m_phase = m_phase;
                endcase
            end
            #1;
            chk("stall", bus.stall, m_phase != 0);
            chk("mem_req", bus.mem_req, m_phase == 1);
            if (m_phase == 1)
                chk("mem_addr", bus.mem_addr, m_base + 32'(4 * ((m_start + m_n) % 4)));
            else if (m_fresh)
                chk("mem_addr_rst", bus.mem_addr, 32'd0);
            chk("line_valid", bus.line_valid, m_phase == 2);
            chk("dataline", bus.dataline, e_dataline);
            chk("line_addr", bus.line_addr, e_line_addr);
            chk("crit_valid", bus.crit_valid, e_crit_valid);
            chk("crit_word", bus.crit_word, e_crit_word);
            chk("refill_err", bus.refill_err, m_phase == 4);
            if (bus.line_valid) begin
                lv_count++;
                cap_line  = bus.dataline;
                cap_laddr = bus.line_addr;
            end
            if (bus.crit_valid) cap_crit = bus.crit_word;
            if (bus.mem_req) req_cycles++;
        end
    end

    // Instruction memory: acks a request after a chosen latency, optionally with stray acks when idle.
    initial begin : responder
        int wc, lat_cur;
        wc = 0; lat_cur = 0;
        bus.mem_ack = 1'b0; bus.mem_rdata = 32'd0;
        forever begin
            @(negedge clk);
            if (bus.mem_req) begin
                if (wc == 0) lat_cur = (lat_mode < 0) ? int'($urandom_range(0, 6)) : lat_mode;
                if (wc >= lat_cur) begin
                    bus.mem_ack   = 1'b1;
                    bus.mem_rdata = fixed_data ? (32'hA0 + {30'd0, bus.mem_addr[3:2]}) : $urandom;
                    acc_q.push_back(bus.mem_addr);
                    wc = 0;
                end else begin
                    bus.mem_ack   = 1'b0;
                    bus.mem_rdata = $urandom;
                    wc++;
                end
            end else begin
                wc = 0;
                bus.mem_ack   = spur_en ? 1'($urandom_range(0, 1)) : 1'b0;
                bus.mem_rdata = $urandom;
            end
        end
    end

    task automatic do_miss(input logic [31:0] addr);
        @(negedge clk);
        bus.miss_req  = 1'b1;
        bus.miss_addr = addr;
        @(negedge clk);
        bus.miss_req  = 1'b0;
        bus.miss_addr = $urandom;
    endtask

    task automatic wait_refill(input int budget);
        int n;
        n = 0;
        while (bus.stall && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("refill_done", bus.stall, 1'b0);
    endtask

    // Directed scenarios followed by a random soak.
    initial begin : main
        int a0, l0, r0, n;
        logic [31:0] ord_plain [4];
        logic [31:0] ord_crit  [4];
        ord_plain = '{32'h120, 32'h124, 32'h128, 32'h12C};
        ord_crit  = '{32'h124, 32'h128, 32'h12C, 32'h120};
        reset = 1'b1; bus.miss_req = 1'b0; bus.miss_addr = 32'd0;
        repeat (3) @(negedge clk);
        chk("rst_stall", bus.stall, 1'b0);
        chk("rst_mem_req", bus.mem_req, 1'b0);
        reset = 1'b0;

        // basic line fill with known data
        a0 = acc_q.size(); l0 = lv_count;
        do_miss(32'h0000_0124);
        wait_refill(100);
        chk("t1_lv_count", lv_count - l0, 1);
        chk("t1_dataline", cap_line, 128'h000000A3_000000A2_000000A1_000000A0);
        chk("t1_model_line", e_dataline, 128'h000000A3_000000A2_000000A1_000000A0);
        chk("t1_line_addr", cap_laddr, 32'h120);
        chk("t1_crit_word", cap_crit, CRIT ? 32'hA1 : 32'h0);
        for (int k = 0; k < 4; k++)
            chk($sformatf("t1_order%0d", k), acc_q[a0 + k], CRIT ? ord_crit[k] : ord_plain[k]);

        // slow memory, five idle cycles per word
        fixed_data = 1'b0; lat_mode = 5; l0 = lv_count;
        do_miss($urandom);
        wait_refill(200);
        chk("t3_lv_count", lv_count - l0, 1);
        chk("t3_err", bus.refill_err, 1'b0);

        // miss held high throughout, stray acks while idle
        spur_en = 1'b1; lat_mode = -1; l0 = lv_count;
        for (int c = 0; c < 150; c++) begin
            @(negedge clk);
            bus.miss_req = 1'b1; bus.miss_addr = $urandom;
        end
        @(negedge clk);
        bus.miss_req = 1'b0;
        wait_refill(200);
        chk("t6_refills", (lv_count - l0) >= 2, 1'b1);

        // random soak
        for (int c = 0; c < 800; c++) begin
            @(negedge clk);
            bus.miss_req  = ($urandom_range(0, 3) == 0);
            bus.miss_addr = $urandom;
        end
        @(negedge clk);
        bus.miss_req = 1'b0;
        wait_refill(200);

        // reset part-way through a fill
        spur_en = 1'b0; lat_mode = 2; a0 = acc_q.size(); l0 = lv_count;
        do_miss($urandom);
        n = 0;
        while ((acc_q.size() - a0) < 2 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("t5_two_acks", (acc_q.size() - a0) >= 2, 1'b1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("t5_req_off", bus.mem_req, 1'b0);
        lat_mode = 1;
        do_miss(32'h0000_0200);
        wait_refill(100);
        chk("t5_lv_count", lv_count - l0, 1);
        chk("t5_line_addr", cap_laddr, 32'h200);

        // memory never answers
        lat_mode = 100000; r0 = req_cycles;
        do_miss($urandom);
        n = 0;
        while (!bus.refill_err && n < 50) begin
            @(negedge clk);
            n++;
        end
        repeat (4) @(negedge clk);
        chk("t4_err", bus.refill_err, 1'b1);
        chk("t4_req_cycles", req_cycles - r0, 8);
        chk("t4_stall", bus.stall, 1'b1);
        chk("t4_req_off", bus.mem_req, 1'b0);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk("t4_rst_err", bus.refill_err, 1'b0);
        chk("t4_rst_stall", bus.stall, 1'b0);
        chk("t4_rst_dataline", bus.dataline, 128'd0);
        chk("t4_rst_line_addr", bus.line_addr, 32'd0);
        repeat (3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
